// File: rtl/if_line_fetch_pkg.sv
// rtl/if_line_fetch_pkg.sv - shared types and constants for the LC-3b instruction fetch stage
package if_line_fetch_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [11:0]  lc3b_line_tag;
    typedef logic [127:0] lc3b_line;

    localparam logic [1:0] FS_RUN          = 2'd0;
    localparam logic [1:0] FS_FILL         = 2'd1;
    localparam logic [1:0] FS_FILL_DISCARD = 2'd2;

    localparam lc3b_word DEFAULT_RESET_PC = 16'h0000;

    function automatic lc3b_line_tag tag_of(input lc3b_word addr);
        return addr[15:4];
    endfunction

endpackage

// File: rtl/if_line_fetch_word_select.sv
// rtl/if_line_fetch_word_select.sv - combinational 128->16 word mux for one cache line
module line_word_select
    import if_line_fetch_pkg::*;
(
    input  lc3b_line   line_i,
    input  logic [2:0] index_i,
    output lc3b_word   word_o
);

    assign word_o = line_i[{index_i, 4'b0000} +: 16];

endmodule

// File: rtl/if_line_fetch.sv
// rtl/if_line_fetch.sv - one-line-buffer instruction fetch with I-cache miss handling and redirects
module if_line_fetch
    import if_line_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          stall,
    input  logic          redirect,
    input  logic [15:0]   target_pc,
    output logic          icache_read,
    output logic [15:0]   icache_address,
    input  logic          icache_resp,
    input  logic [127:0]  icache_rdata,
    output logic [15:0]   ir,
    output logic [15:0]   ir_pc,
    output logic [15:0]   ir_pc_plus2,
    output logic          ir_valid
);

    logic [1:0]   state_q, state_d;
    lc3b_word     pc_q, pc_d;
    lc3b_line     line_q, line_d;
    lc3b_line_tag line_tag_q, line_tag_d;
    logic         line_valid_q, line_valid_d;
    lc3b_line_tag miss_tag_q, miss_tag_d;
    logic         icache_read_q, icache_read_d;
    lc3b_word     icache_address_q, icache_address_d;
    lc3b_word     ir_q, ir_d;
    lc3b_word     ir_pc_q, ir_pc_d;
    lc3b_word     ir_pc_plus2_q, ir_pc_plus2_d;
    logic         ir_valid_q, ir_valid_d;

    lc3b_word     buf_word;
    lc3b_word     bypass_word;
    lc3b_word     target_even;
    logic         hit;

    // Same index drives both muxes: during a fill pc still points at the missed word.
    line_word_select u_buf_sel (
        .line_i  (line_q),
        .index_i (pc_q[3:1]),
        .word_o  (buf_word)
    );

    line_word_select u_bypass_sel (
        .line_i  (icache_rdata),
        .index_i (pc_q[3:1]),
        .word_o  (bypass_word)
    );

    assign target_even = target_pc & 16'hFFFE;
    assign hit         = line_valid_q && (line_tag_q == tag_of(pc_q));

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        line_d           = line_q;
        line_tag_d       = line_tag_q;
        line_valid_d     = line_valid_q;
        miss_tag_d       = miss_tag_q;
        icache_read_d    = icache_read_q;
        icache_address_d = icache_address_q;
        ir_d             = ir_q;
        ir_pc_d          = ir_pc_q;
        ir_pc_plus2_d    = ir_pc_plus2_q;
        ir_valid_d       = ir_valid_q;

        case (state_q)
            FS_RUN: begin
                if (redirect) begin
                    pc_d       = target_even;
                    ir_valid_d = 1'b0;
                end else if (!stall) begin
                    if (hit) begin
                        ir_d          = buf_word;
                        ir_pc_d       = pc_q;
                        ir_pc_plus2_d = pc_q + 16'd2;
                        ir_valid_d    = 1'b1;
                        pc_d          = pc_q + 16'd2;
                    end else begin
                        ir_valid_d       = 1'b0;
                        miss_tag_d       = tag_of(pc_q);
                        icache_read_d    = 1'b1;
                        icache_address_d = {tag_of(pc_q), 4'b0000};
                        state_d          = FS_FILL;
                    end
                end
            end
            FS_FILL, FS_FILL_DISCARD: begin
                // The outstanding request is always completed; only delivery is affected.
                if (icache_resp) begin
                    line_d        = icache_rdata;
                    line_tag_d    = miss_tag_q;
                    line_valid_d  = 1'b1;
                    icache_read_d = 1'b0;
                    state_d       = FS_RUN;
                end else if (redirect) begin
                    state_d = FS_FILL_DISCARD;
                end

                if (redirect) begin
                    pc_d       = target_even;
                    ir_valid_d = 1'b0;
                end else if (icache_resp && !stall && state_q == FS_FILL) begin
                    ir_d          = bypass_word;
                    ir_pc_d       = pc_q;
                    ir_pc_plus2_d = pc_q + 16'd2;
                    ir_valid_d    = 1'b1;
                    pc_d          = pc_q + 16'd2;
                end

                if (state_q == FS_FILL_DISCARD && icache_resp) begin
                    ir_valid_d = 1'b0;
                end
            end
            default: state_d = FS_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q          <= FS_RUN;
            pc_q             <= RESET_PC & 16'hFFFE;
            line_q           <= '0;
            line_tag_q       <= '0;
            line_valid_q     <= 1'b0;
            miss_tag_q       <= '0;
            icache_read_q    <= 1'b0;
            icache_address_q <= '0;
            ir_q             <= '0;
            ir_pc_q          <= '0;
            ir_pc_plus2_q    <= '0;
            ir_valid_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            line_q           <= line_d;
            line_tag_q       <= line_tag_d;
            line_valid_q     <= line_valid_d;
            miss_tag_q       <= miss_tag_d;
            icache_read_q    <= icache_read_d;
            icache_address_q <= icache_address_d;
            ir_q             <= ir_d;
            ir_pc_q          <= ir_pc_d;
            ir_pc_plus2_q    <= ir_pc_plus2_d;
            ir_valid_q       <= ir_valid_d;
        end
    end

    assign icache_read    = icache_read_q;
    assign icache_address = icache_address_q;
    assign ir             = ir_q;
    assign ir_pc          = ir_pc_q;
    assign ir_pc_plus2    = ir_pc_plus2_q;
    assign ir_valid       = ir_valid_q;

endmodule
